// File: rtl/dash_scan_display.sv
// Two-half multiplexed 7-segment scanner with a shared double-dabble
// converter, leading-zero blanking, per-half blink and PWM dimming.
module dash_scan_display #(
  parameter int DIGITS      = 8,
  parameter int VAL_W       = 14,
  parameter int BLINK_TICKS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_scan,
  input  logic [VAL_W-1:0]  left_val,
  input  logic [VAL_W-1:0]  right_val,
  input  logic              warn_left,
  input  logic              warn_right,
  input  logic [1:0]        bright,
  output logic [7:0]        seg_data,
  output logic [DIGITS-1:0] seg_com,
  output logic              conv_busy
);
  localparam int H  = DIGITS / 2;
  localparam int BW = 4 * H;
  localparam int CW = $clog2(VAL_W + 1);
  localparam int KW = $clog2(2 * BLINK_TICKS);
  localparam logic [31:0]   SAT   = 32'(10 ** H - 1);
  localparam logic [2:0]    LAST  = 3'(DIGITS - 1);
  localparam logic [2:0]    HALF  = 3'(H);
  localparam logic [KW-1:0] BT    = KW'(BLINK_TICKS);
  localparam logic [KW-1:0] BMAX  = KW'(2 * BLINK_TICKS - 1);
  localparam logic [CW-1:0] SLAST = CW'(VAL_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  function automatic logic [VAL_W-1:0] sat(
    input logic [VAL_W-1:0] v
  );
    if (32'(v) > SAT) return VAL_W'(SAT);
    return v;
  endfunction

  function automatic logic [BW-1:0] dabble(
    input logic [BW-1:0] b
  );
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < H; i++)
      if (r[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] seg7(
    input logic [3:0] d
  );
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Digit 0 of a half is never blanked, even for a zero value.
  function automatic logic [H-1:0][7:0] blank_lz(
    input logic [BW-1:0] b
  );
    logic [H-1:0][7:0] r;
    logic lead;
    lead = 1'b1;
    for (int i = H - 1; i >= 0; i--) begin
      if (lead && i != 0 && b[4*i +: 4] == 4'd0) begin
        r[i] = 8'h00;
      end else begin
        lead = 1'b0;
        r[i] = seg7(b[4*i +: 4]);
      end
    end
    return r;
  endfunction

  state_t state, state_nxt;
  logic [2:0]             scan_idx;
  logic [KW-1:0]          blink_cnt;
  logic [1:0]             pwm;
  logic [CW-1:0]          cnt;
  logic [VAL_W-1:0]       bin_l, bin_r;
  logic [BW-1:0]          bcd_l, bcd_r;
  logic [DIGITS-1:0][7:0] disp;
  logic                   frame, half_l, blank, lit;
  logic [DIGITS-1:0]      com_nxt;

  assign frame     = tick_scan && scan_idx == LAST;
  assign conv_busy = state != IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == SLAST) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      bin_l <= '0;
      bin_r <= '0;
      bcd_l <= '0;
      bcd_r <= '0;
      disp  <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          bin_l <= sat(left_val);
          bin_r <= sat(right_val);
          bcd_l <= '0;
          bcd_r <= '0;
          cnt   <= '0;
        end
        SHIFT: begin
          {bcd_l, bin_l} <= {dabble(bcd_l), bin_l} << 1;
          {bcd_r, bin_r} <= {dabble(bcd_r), bin_r} << 1;
          cnt <= cnt + CW'(1);
        end
        COMMIT: begin
          disp[DIGITS-1:H] <= blank_lz(bcd_l);
          disp[H-1:0]      <= blank_lz(bcd_r);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx  <= '0;
      blink_cnt <= '0;
      pwm       <= '0;
    end else begin
      pwm <= pwm + 2'd1;
      if (tick_scan) begin
        scan_idx  <= (scan_idx == LAST) ? 3'd0
                   : scan_idx + 3'd1;
        blink_cnt <= (blink_cnt == BMAX) ? '0
                   : blink_cnt + KW'(1);
      end
    end
  end

  assign half_l = scan_idx >= HALF;
  assign blank  = (blink_cnt >= BT)
               && (half_l ? warn_left : warn_right);
  assign lit    = (pwm <= bright);

  always_comb begin
    com_nxt = '1;
    for (int i = 0; i < DIGITS; i++)
      if (lit && scan_idx == 3'(i)) com_nxt[i] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_data <= 8'h00;
      seg_com  <= '1;
    end else begin
      seg_data <= blank ? 8'h00 : disp[scan_idx];
      seg_com  <= com_nxt;
    end
  end
endmodule

// File: doc/dash_scan_display.md
DASH_SCAN_DISPLAY -- requirements
Module: dash_scan_display

Interface
REQ-001 Parameter DIGITS, default 8, total multiplexed digits; even, 4..8; H = DIGITS/2 digits per half.
REQ-002 Parameter VAL_W, default 14, binary input value width, 4..16.
REQ-003 Parameter BLINK_TICKS, default 256, tick_scan pulses per blink half-period; must be at least 2.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tick_scan  input  1  single-cycle digit-advance strobe; consecutive pulses at least VAL_W+4 clocks apart.
REQ-007 left_val  input  VAL_W  unsigned value for the left half (digits H..DIGITS-1).
REQ-008 right_val  input  VAL_W  unsigned value for the right half (digits 0..H-1).
REQ-009 warn_left, warn_right  input  1 each  blink request for the corresponding half.
REQ-010 bright  input  2  brightness level 0 (25%) .. 3 (100%).
REQ-011 seg_data  output  8  segment pattern, active-high, bit0=a .. bit6=g, bit7=dp (always 0).
REQ-012 seg_com  output  DIGITS  digit commons, active-low; at most one bit low.
REQ-013 conv_busy  output  1  high while the BCD converter is running.

Function
REQ-014 scan_idx (3-bit) increments modulo DIGITS on each tick_scan; seg_com[scan_idx] low when enabled, all others high.
REQ-015 Frame start is the tick_scan that wraps scan_idx from DIGITS-1 to 0.
REQ-016 Converter FSM states IDLE, LOAD, SHIFT, COMMIT; IDLE->LOAD on frame start; LOAD->SHIFT after 1 clock; SHIFT lasts exactly VAL_W clocks; SHIFT->COMMIT; COMMIT->IDLE after 1 clock.
REQ-017 LOAD samples left_val and right_val, each saturated to 10^H-1 (9999 for H=4).
REQ-018 SHIFT performs one shift-and-add-3 (double dabble) iteration per clock per half; both halves convert in parallel.
REQ-019 COMMIT copies both BCD results into the display registers in the same clock; display registers change on no other cycle.
REQ-020 Commit latency: display registers update VAL_W+3 clocks after the frame-start tick_scan.
REQ-021 conv_busy high in LOAD, SHIFT and COMMIT, low in IDLE.
REQ-022 A frame start while conv_busy is high is ignored; the running conversion completes undisturbed.
REQ-023 Scanning continues during conversion, using the previous display registers.
REQ-024 Leading-zero blanking applies per half at COMMIT: leading zero digits become blank (all segments off); the least-significant digit of each half is never blanked.
REQ-025 Digit encoding: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F; blank=0x00.
REQ-026 Blink counter counts tick_scan pulses modulo 2*BLINK_TICKS; the off phase is counts BLINK_TICKS..2*BLINK_TICKS-1.
REQ-027 During the off phase, digits of a half whose warn input is high output seg_data=0x00; seg_com scanning is unchanged.
REQ-028 Dimming: a free-running 2-bit clock counter pwm; the active common is driven low only while pwm <= bright, otherwise all commons are high.
REQ-029 seg_data and seg_com are registered; they reflect scan_idx one clock after its update.
REQ-030 If warn and dimming apply simultaneously, blink blanking takes precedence over the segment pattern; dimming still gates the commons.

Reset
REQ-031 While rst is high: scan_idx=0, FSM=IDLE, blink counter=0, pwm=0, every display register blank, seg_com all ones, seg_data=0x00, conv_busy=0.
REQ-032 rst asserted mid-conversion aborts it; no partial result is committed.
REQ-033 After rst release, all digits stay blank until the first COMMIT.

Verification
REQ-034 left_val=1234, right_val=7, DIGITS=8 -> after first COMMIT digits 7..4 show 1,2,3,4; digits 3..1 blank; digit 0 shows 0x07.
REQ-035 right_val=16383 with VAL_W=14 -> right half shows 9999; left_val=0 -> digits 7..5 blank, digit 4 shows 0x3F.
REQ-036 Frame start, then a second forced tick_scan wrap 5 clocks later -> conv_busy stays high exactly 16 clocks total; one COMMIT only.
REQ-037 rst pulsed at SHIFT clock 6 -> outputs return to reset values; display stays blank until the next full conversion.
REQ-038 warn_right=1, BLINK_TICKS=2 -> right-half seg_data 0x00 for tick counts 2..3 of every 4; left half unaffected.
REQ-039 bright=0 -> each seg_com bit is low in exactly 1 of every 4 clocks within its slot; bright=3 -> low continuously.
